// File: rtl/rx_arb_pkg.sv
// Shared types and constants for the RX FIFO arbiter.
// Imported by the serializer and the arbiter top.
package rx_arb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    PULL,
    CAPTURE,
    SEND
  } state_t;

  localparam logic CH_09 = 1'b0;
  localparam logic CH_24 = 1'b1;

  localparam int WORD_W = 32;
  localparam int BYTE_W = 8;

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hff) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/rx_word_serializer.sv
// Holds one 32-bit I/Q word and emits it MSB byte first
// over a valid/ready handshake; done pulses on the last accept.
module rx_word_serializer
  import rx_arb_pkg::*;
(
  input  logic              i_sys_clk,
  input  logic              i_rst_b,
  input  logic              load,
  input  logic [WORD_W-1:0] word,
  output logic [BYTE_W-1:0] data,
  output logic              valid,
  input  logic              ready,
  output logic              last,
  output logic              done
);

  logic [WORD_W-1:0] word_q;
  logic [1:0]        idx_q;
  logic              valid_q;

  always_ff @(posedge i_sys_clk or negedge i_rst_b) begin
    if (!i_rst_b) begin
      word_q  <= '0;
      idx_q   <= 2'd3;
      valid_q <= 1'b0;
    end else if (load) begin
      word_q  <= word;
      idx_q   <= 2'd3;
      valid_q <= 1'b1;
    end else if (done) begin
      idx_q   <= 2'd3;
      valid_q <= 1'b0;
    end else if (valid_q && ready) begin
      idx_q <= idx_q - 2'd1;
    end
  end

  assign data  = word_q[{idx_q, 3'b000} +: BYTE_W];
  assign valid = valid_q;
  assign last  = valid_q && (idx_q == 2'd0);
  assign done  = last && ready;

endmodule

// File: rtl/rx_fifo_arbiter.sv
// Round-robin, burst-bounded scheduler feeding the SMI byte
// stream from the 0.9 GHz and 2.4 GHz RX sample FIFOs.
module rx_fifo_arbiter
  import rx_arb_pkg::*;
#(
  parameter int BURST_LEN = 16
) (
  input  logic        i_sys_clk,
  input  logic        i_rst_b,
  input  logic [1:0]  i_ch_en,
  output logic        o_fifo_09_pull,
  input  logic [31:0] i_fifo_09_data,
  input  logic        i_fifo_09_empty,
  output logic        o_fifo_24_pull,
  input  logic [31:0] i_fifo_24_data,
  input  logic        i_fifo_24_empty,
  output logic [7:0]  o_byte,
  output logic        o_byte_valid,
  input  logic        i_byte_ready,
  output logic        o_byte_ch,
  output logic        o_byte_last,
  output logic [1:0]  o_grant
);

  localparam logic [7:0] BL = 8'(BURST_LEN);

  state_t      state_q;
  state_t      state_d;
  logic        ptr_q;
  logic        ch_q;
  logic [7:0]  cnt_q;
  logic [7:0]  cnt_inc;
  logic [1:0]  grant_q;
  logic [1:0]  pull_q;
  logic [1:0]  pull_d;
  logic [1:0]  elig;
  logic        pick;
  logic        start;
  logic        cont;
  logic        go_pull;
  logic        next_ch;
  logic        done;
  logic        load;
  logic [WORD_W-1:0] word;

  assign elig    = i_ch_en & ~{i_fifo_24_empty, i_fifo_09_empty};
  assign cnt_inc = sat_inc(cnt_q);

  always_ff @(posedge i_sys_clk or negedge i_rst_b) begin
    if (!i_rst_b) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (|elig) state_d = PULL;
      PULL:    state_d = CAPTURE;
      CAPTURE: state_d = SEND;
      SEND:    if (done) state_d = cont ? PULL : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Burst limit only matters while the other channel is waiting.
  always_comb begin
    pick = CH_09;
    unique case (elig)
      2'b11:   pick = ptr_q;
      2'b10:   pick = CH_24;
      default: pick = CH_09;
    endcase
    cont    = elig[ch_q] && ((cnt_inc < BL) || !elig[~ch_q]);
    start   = (state_q == IDLE) && (|elig);
    next_ch = start ? pick : ch_q;
    go_pull = start || ((state_q == SEND) && done && cont);
    pull_d  = '0;
    if (go_pull) pull_d = next_ch ? 2'b10 : 2'b01;
  end

  always_ff @(posedge i_sys_clk or negedge i_rst_b) begin
    if (!i_rst_b) begin
      ptr_q   <= CH_09;
      ch_q    <= CH_09;
      cnt_q   <= '0;
      grant_q <= '0;
      pull_q  <= '0;
    end else begin
      pull_q <= pull_d;
      if (start) begin
        ch_q    <= pick;
        grant_q <= pick ? 2'b10 : 2'b01;
        cnt_q   <= '0;
      end
      if ((state_q == SEND) && done) begin
        cnt_q <= cnt_inc;
        if (!cont) begin
          grant_q <= '0;
          ptr_q   <= ~ch_q;
        end
      end
    end
  end

  assign load = (state_q == CAPTURE);
  assign word = ch_q ? i_fifo_24_data : i_fifo_09_data;

  rx_word_serializer u_ser (
    .i_sys_clk (i_sys_clk),
    .i_rst_b   (i_rst_b),
    .load      (load),
    .word      (word),
    .data      (o_byte),
    .valid     (o_byte_valid),
    .ready     (i_byte_ready),
    .last      (o_byte_last),
    .done      (done)
  );

  assign o_fifo_09_pull = pull_q[0];
  assign o_fifo_24_pull = pull_q[1];
  assign o_grant        = grant_q;
  assign o_byte_ch      = ch_q;

endmodule

// File: tb/tb_rx_fifo_arbiter.sv
// Scoreboard bench for rx_fifo_arbiter with two FIFO models,
// directed word vectors and hand-derived arbitration order.
module tb_rx_fifo_arbiter;

  logic        clk = 1'b0;
  logic        rst_b = 1'b0;
  logic [1:0]  en = 2'b00;
  logic        rdy = 1'b0;
  logic        p09, p24;
  logic        e09 = 1'b1, e24 = 1'b1;
  logic [31:0] d09 = '0, d24 = '0;
  logic [7:0]  ob;
  logic        ov, och, olast;
  logic [1:0]  og;

  always #5 clk = ~clk;

  rx_fifo_arbiter #(.BURST_LEN(2)) dut (
    .i_sys_clk       (clk),
    .i_rst_b         (rst_b),
    .i_ch_en         (en),
    .o_fifo_09_pull  (p09),
    .i_fifo_09_data  (d09),
    .i_fifo_09_empty (e09),
    .o_fifo_24_pull  (p24),
    .i_fifo_24_data  (d24),
    .i_fifo_24_empty (e24),
    .o_byte          (ob),
    .o_byte_valid    (ov),
    .i_byte_ready    (rdy),
    .o_byte_ch       (och),
    .o_byte_last     (olast),
    .o_grant         (og)
  );

  typedef struct packed {
    logic       ch;
    logic [7:0] b;
    logic       last;
  } exp_t;

  logic [31:0] q09[$];
  logic [31:0] q24[$];
  exp_t        sb[$];
  exp_t        e;
  int          tacc[$];
  int          cyc = 0;
  int          n_checks = 0;
  int          n_errors = 0;
  int          n_p24 = 0;
  int          t0;
  int          k;

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(posedge clk) cyc++;

  // FIFO models: data appears the cycle after the pull.
  always @(posedge clk) begin
    if (p09) begin
      chk("pull09_legal", {en[0], q09.size() != 0}, 2'b11);
      if (q09.size() != 0) d09 <= q09.pop_front();
    end
    if (p24) begin
      n_p24++;
      chk("pull24_legal", {en[1], q24.size() != 0}, 2'b11);
      if (q24.size() != 0) d24 <= q24.pop_front();
    end
  end

  always @(negedge clk) begin
    e09 = (q09.size() == 0);
    e24 = (q24.size() == 0);
  end

  logic       pv = 1'b0, pr = 1'b0, pch = 1'b0;
  logic [7:0] pb = '0;

  // Monitor: pops the scoreboard on every accepted byte.
  always @(negedge clk) begin
    if (!rst_b) begin
      pv = 1'b0;
    end else begin
      if (pv && !pr) begin
        chk("hold_valid", ov, 1'b1);
        chk("hold_byte", {och, ob}, {pch, pb});
      end
      if (p09 || p24) chk("pull_onehot", p09 & p24, 1'b0);
      if (ov && rdy) begin
        tacc.push_back(cyc);
        if (sb.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL unexpected_byte: got %0h nothing expected", ob);
        end else begin
          e = sb.pop_front();
          chk("byte", {och, ob, olast}, {e.ch, e.b, e.last});
        end
      end
      pv = ov; pr = rdy; pb = ob; pch = och;
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic exp_word(input logic ch, input logic [31:0] w);
    for (int i = 3; i >= 0; i--)
      sb.push_back('{ch, w[i*8 +: 8], i == 0});
  endtask

  task automatic do_reset();
    rst_b = 1'b0;
    en = 2'b00;
    rdy = 1'b0;
    q09.delete();
    q24.delete();
    sb.delete();
    step(2);
    rst_b = 1'b1;
    step(1);
    tacc.delete();
  endtask

  task automatic drain(input string name);
    int n = 0;
    while ((sb.size() != 0 || ov || og != 2'b00) && n < 400) begin
      step(1);
      n++;
    end
    chk({name, "_timeout"}, n < 400, 1'b1);
    chk({name, "_sb_left"}, sb.size(), 0);
  endtask

  function automatic int tdiff(input int a, input int b);
    return (tacc.size() > b) ? tacc[b] - tacc[a] : -1;
  endfunction

  logic [3:0] pat = 4'b1001;

  initial begin
    #1;
    chk("reset_outputs", {ob, ov, och, olast, og, p09, p24}, '0);
    step(2);
    rst_b = 1'b1;
    step(1);

    // Single channel, latency and 6-cycle word rate.
    rdy = 1'b1;
    q09.push_back(32'h11223344); q09.push_back(32'hAABBCCDD);
    exp_word(1'b0, 32'h11223344); exp_word(1'b0, 32'hAABBCCDD);
    tacc.delete();
    step(2);
    en = 2'b01;
    t0 = cyc;
    drain("t1");
    chk("t1_nbytes", tacc.size(), 8);
    chk("t1_latency", (tacc.size() > 0) ? tacc[0] - t0 : -1, 3);
    chk("t1_rate", tdiff(0, 4), 6);
    chk("t1_no24pull", n_p24, 0);

    // Both busy, burst 2: 09,09,24,24,09,24.
    do_reset();
    rdy = 1'b1;
    q09.push_back(32'h01020304); q09.push_back(32'h05060708);
    q09.push_back(32'h090A0B0C);
    q24.push_back(32'hF1F2F3F4); q24.push_back(32'hE1E2E3E4);
    q24.push_back(32'hD1D2D3D4);
    exp_word(1'b0, 32'h01020304); exp_word(1'b0, 32'h05060708);
    exp_word(1'b1, 32'hF1F2F3F4); exp_word(1'b1, 32'hE1E2E3E4);
    exp_word(1'b0, 32'h090A0B0C); exp_word(1'b1, 32'hD1D2D3D4);
    step(2);
    en = 2'b11;
    drain("t2");

    // 2.4 GHz drains after one word; 0.9 GHz runs past the burst limit.
    do_reset();
    rdy = 1'b1;
    for (int i = 1; i <= 5; i++) q09.push_back(32'hA0A0A000 + i);
    q24.push_back(32'hB0B0B001);
    exp_word(1'b0, 32'hA0A0A001); exp_word(1'b0, 32'hA0A0A002);
    exp_word(1'b1, 32'hB0B0B001); exp_word(1'b0, 32'hA0A0A003);
    exp_word(1'b0, 32'hA0A0A004); exp_word(1'b0, 32'hA0A0A005);
    step(2);
    en = 2'b11;
    drain("t3");
    chk("t3_gap_a", tdiff(12, 16), 6);
    chk("t3_gap_b", tdiff(16, 20), 6);

    // Ready toggled 1-0-0-1 while sending.
    do_reset();
    q24.push_back(32'hCAFEF00D);
    exp_word(1'b1, 32'hCAFEF00D);
    step(2);
    en = 2'b10;
    for (int i = 0; i < 200 && sb.size() != 0; i++) begin
      rdy = pat[i % 4];
      step(1);
    end
    rdy = 1'b1;
    drain("t4");

    // Enable dropped mid-word: that word completes, nothing more pulled.
    do_reset();
    rdy = 1'b1;
    q09.push_back(32'h13579BDF); q09.push_back(32'h2468ACE0);
    q09.push_back(32'h0F1E2D3C);
    exp_word(1'b0, 32'h13579BDF);
    step(2);
    en = 2'b01;
    k = 0;
    while (!ov && k < 50) begin step(1); k++; end
    chk("t5_started", ov, 1'b1);
    en = 2'b00;
    drain("t5");
    step(5);
    chk("t5_left", q09.size(), 2);

    // Reset during byte 2: outputs clear at once, next grant is 0.9 GHz.
    do_reset();
    rdy = 1'b1;
    q09.push_back(32'hC1C1C1C1); q09.push_back(32'hC2C2C2C2);
    q24.push_back(32'hD1D1D1D1);
    exp_word(1'b0, 32'hC1C1C1C1);
    step(2);
    en = 2'b11;
    k = 0;
    while (tacc.size() < 1 && k < 50) begin step(1); k++; end
    chk("t6_first_byte", tacc.size(), 1);
    rst_b = 1'b0;
    #1;
    chk("t6_reset_outputs", {ob, ov, och, olast, og, p09, p24}, '0);
    sb.delete();
    step(1);
    rst_b = 1'b1;
    exp_word(1'b0, 32'hC2C2C2C2);
    exp_word(1'b1, 32'hD1D1D1D1);
    k = 0;
    while (og == 2'b00 && k < 50) begin step(1); k++; end
    chk("t6_grant_09", og, 2'b01);
    drain("t6");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule
